// File: rtl/dram_axi_bridge_if.sv
// Single-beat AXI4 channel bundle between the bridge (master) and the DRAM
// controller (slave). IDs are carried but always driven to zero.
interface dram_axi_bridge_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  arvalid;
    logic                  arready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic [3:0]            arid;

    logic                  rvalid;
    logic                  rready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;

    logic                  awvalid;
    logic                  awready;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic [3:0]            awid;

    logic                  wvalid;
    logic                  wready;
    logic [DATA_WIDTH-1:0] wdata;
    logic [3:0]            wstrb;
    logic                  wlast;

    logic                  bvalid;
    logic                  bready;
    logic [1:0]            bresp;

    modport master (
        output arvalid, araddr, arlen, arsize, arburst, arid,
        input  arready,
        input  rvalid, rdata, rresp, rlast,
        output rready,
        output awvalid, awaddr, awlen, awsize, awburst, awid,
        input  awready,
        output wvalid, wdata, wstrb, wlast,
        input  wready,
        input  bvalid, bresp,
        output bready
    );

    modport slave (
        input  arvalid, araddr, arlen, arsize, arburst, arid,
        output arready,
        output rvalid, rdata, rresp, rlast,
        input  rready,
        input  awvalid, awaddr, awlen, awsize, awburst, awid,
        output awready,
        input  wvalid, wdata, wstrb, wlast,
        output wready,
        output bvalid, bresp,
        input  bready
    );
endinterface

// File: rtl/dram_axi_bridge.sv
// Bridges the core's SRAM-style read/write data port onto single-beat AXI4,
// keeping read-after-write order by holding reads until the write's B returns.
module dram_axi_bridge #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic                  sram_rd_en,
    input  logic [ADDR_WIDTH-1:0] sram_rd_addr,
    input  logic                  sram_cancel_rd,
    output logic [DATA_WIDTH-1:0] sram_rd_data,
    output logic                  sram_rd_valid,

    input  logic                  sram_wr_en,
    input  logic [ADDR_WIDTH-1:0] sram_wr_addr,
    input  logic [DATA_WIDTH-1:0] sram_wr_data,
    input  logic [3:0]            sram_wr_mask,
    output logic                  sram_wr_busy,

    dram_axi_bridge_if.master     axi,

    output logic                  bus_err
);

    typedef enum logic [2:0] {R_IDLE, R_WAIT, R_ADDR, R_DATA, R_DROP} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_SEND, W_RESP} w_state_t;

    r_state_t r_state, r_next;
    w_state_t w_state, w_next;

    logic [ADDR_WIDTH-1:0] rd_addr_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [DATA_WIDTH-1:0] wr_data_q;
    logic [3:0]            wr_mask_q;
    logic                  aw_done;
    logic                  w_done;
    logic                  cancel_pend;

    logic ar_req, r_rdy, aw_req, w_req, b_rdy;
    logic r_fire, aw_fire, w_fire, b_fire;
    logic rd_deliver, wr_accept;
    logic unused_rlast;

    assign unused_rlast = axi.rlast;

    // Fixed single-beat, 32-bit, INCR transfer attributes.
    assign axi.arlen   = '0;
    assign axi.arsize  = 3'b010;
    assign axi.arburst = 2'b01;
    assign axi.arid    = '0;
    assign axi.awlen   = '0;
    assign axi.awsize  = 3'b010;
    assign axi.awburst = 2'b01;
    assign axi.awid    = '0;
    assign axi.wlast   = 1'b1;

    assign ar_req = (r_state == R_ADDR);
    assign r_rdy  = (r_state == R_DATA) || (r_state == R_DROP);
    assign aw_req = (w_state == W_SEND) && !aw_done;
    assign w_req  = (w_state == W_SEND) && !w_done;
    assign b_rdy  = (w_state == W_RESP);

    assign r_fire  = r_rdy  && axi.rvalid;
    assign aw_fire = aw_req && axi.awready;
    assign w_fire  = w_req  && axi.wready;
    assign b_fire  = b_rdy  && axi.bvalid;

    assign axi.arvalid = ar_req;
    assign axi.araddr  = rd_addr_q;
    assign axi.rready  = r_rdy;
    assign axi.awvalid = aw_req;
    assign axi.awaddr  = wr_addr_q;
    assign axi.wvalid  = w_req;
    assign axi.wdata   = wr_data_q;
    assign axi.wstrb   = wr_mask_q;
    assign axi.bready  = b_rdy;

    assign sram_wr_busy = (w_state != W_IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= R_IDLE;
            w_state <= W_IDLE;
        end else begin
            r_state <= r_next;
            w_state <= w_next;
        end
    end

    always_comb begin
        r_next     = r_state;
        rd_deliver = 1'b0;
        case (r_state)
            R_IDLE: begin
                if (sram_rd_en)
                    r_next = (w_state == W_IDLE && !sram_wr_en) ? R_ADDR : R_WAIT;
            end
            R_WAIT: begin
                // Leave as the B beat is taken so AR rises the cycle after it.
                if (sram_cancel_rd)
                    r_next = R_IDLE;
                else if ((w_state == W_RESP && axi.bvalid) ||
                         (w_state == W_IDLE && !sram_wr_en))
                    r_next = R_ADDR;
            end
            R_ADDR: begin
                if (axi.arready)
                    r_next = (sram_cancel_rd || cancel_pend) ? R_DROP : R_DATA;
            end
            R_DATA: begin
                // A cancel coinciding with the R beat simply discards that beat.
                if (axi.rvalid) begin
                    r_next     = R_IDLE;
                    rd_deliver = !sram_cancel_rd;
                end else if (sram_cancel_rd) begin
                    r_next = R_DROP;
                end
            end
            R_DROP: begin
                if (axi.rvalid)
                    r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    always_comb begin
        w_next    = w_state;
        wr_accept = 1'b0;
        case (w_state)
            W_IDLE: begin
                if (sram_wr_en) begin
                    w_next    = W_SEND;
                    wr_accept = 1'b1;
                end
            end
            W_SEND: begin
                if ((aw_done || aw_fire) && (w_done || w_fire))
                    w_next = W_RESP;
            end
            W_RESP: begin
                if (axi.bvalid)
                    w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sram_rd_data  <= '0;
            sram_rd_valid <= 1'b0;
            bus_err       <= 1'b0;
            rd_addr_q     <= '0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            wr_mask_q     <= '0;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            cancel_pend   <= 1'b0;
        end else begin
            sram_rd_valid <= rd_deliver;
            if (rd_deliver)
                sram_rd_data <= axi.rdata;
            bus_err <= (r_fire && axi.rresp != 2'b00) || (b_fire && axi.bresp != 2'b00);

            if (r_state == R_IDLE && sram_rd_en)
                rd_addr_q <= sram_rd_addr;

            // A cancel pulse seen while AR is stalled must survive until arready.
            if (r_state == R_ADDR)
                cancel_pend <= cancel_pend || sram_cancel_rd;
            else
                cancel_pend <= 1'b0;

            if (wr_accept) begin
                wr_addr_q <= sram_wr_addr;
                wr_data_q <= sram_wr_data;
                wr_mask_q <= sram_wr_mask;
                aw_done   <= 1'b0;
                w_done    <= 1'b0;
            end else if (w_state == W_SEND) begin
                aw_done <= aw_done || aw_fire;
                w_done  <= w_done  || w_fire;
            end
        end
    end

endmodule

// File: tb/tb_dram_axi_bridge.sv
// Directed bench for dram_axi_bridge: the AXI slave side is driven by hand,
// cycle by cycle, and every expectation is a hand-computed constant.
module tb_dram_axi_bridge;

    logic        clock = 1'b0;
    logic        reset;
    logic        sram_rd_en;
    logic [31:0] sram_rd_addr;
    logic        sram_cancel_rd;
    logic [31:0] sram_rd_data;
    logic        sram_rd_valid;
    logic        sram_wr_en;
    logic [31:0] sram_wr_addr;
    logic [31:0] sram_wr_data;
    logic [3:0]  sram_wr_mask;
    logic        sram_wr_busy;
    logic        bus_err;

    int checks = 0;
    int errors = 0;
    int ar_cnt = 0;
    int aw_cnt = 0;
    int w_cnt  = 0;
    int b_cnt  = 0;

    dram_axi_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axi ();

    dram_axi_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .sram_rd_en     (sram_rd_en),
        .sram_rd_addr   (sram_rd_addr),
        .sram_cancel_rd (sram_cancel_rd),
        .sram_rd_data   (sram_rd_data),
        .sram_rd_valid  (sram_rd_valid),
        .sram_wr_en     (sram_wr_en),
        .sram_wr_addr   (sram_wr_addr),
        .sram_wr_data   (sram_wr_data),
        .sram_wr_mask   (sram_wr_mask),
        .sram_wr_busy   (sram_wr_busy),
        .axi            (axi.master),
        .bus_err        (bus_err)
    );

    always #5 clock = ~clock;

    // Handshake counters on the AXI channels.
    always @(posedge clock) begin
        if (!reset) begin
            if (axi.arvalid && axi.arready) ar_cnt <= ar_cnt + 1;
            if (axi.awvalid && axi.awready) aw_cnt <= aw_cnt + 1;
            if (axi.wvalid  && axi.wready)  w_cnt  <= w_cnt + 1;
            if (axi.bvalid  && axi.bready)  b_cnt  <= b_cnt + 1;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        sram_rd_en = 0; sram_rd_addr = '0; sram_cancel_rd = 0;
        sram_wr_en = 0; sram_wr_addr = '0; sram_wr_data = '0; sram_wr_mask = '0;
        axi.arready = 0; axi.rvalid = 0; axi.rdata = '0; axi.rresp = '0; axi.rlast = 1;
        axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bresp = '0;

        // Reset state
        tick(); tick();
        chk("rst_arvalid", axi.arvalid, 0);
        chk("rst_rready", axi.rready, 0);
        chk("rst_awvalid", axi.awvalid, 0);
        chk("rst_wvalid", axi.wvalid, 0);
        chk("rst_bready", axi.bready, 0);
        chk("rst_rd_valid", sram_rd_valid, 0);
        chk("rst_wr_busy", sram_wr_busy, 0);
        chk("rst_bus_err", bus_err, 0);
        chk("rst_rd_data", sram_rd_data, 0);
        chk("const_arlen", axi.arlen, 0);
        chk("const_arsize", axi.arsize, 3'b010);
        chk("const_awburst", axi.awburst, 2'b01);
        chk("const_wlast", axi.wlast, 1);
        reset = 1'b0;
        tick();

        // Minimum-latency read
        sram_rd_en = 1; sram_rd_addr = 32'h1C00_0000; axi.arready = 1;
        chk("rd_t_arvalid", axi.arvalid, 0);
        tick();
        sram_rd_en = 0;
        chk("rd_t1_arvalid", axi.arvalid, 1);
        chk("rd_t1_araddr", axi.araddr, 32'h1C00_0000);
        chk("rd_t1_rready", axi.rready, 0);
        tick();
        chk("rd_t2_arvalid", axi.arvalid, 0);
        chk("rd_t2_rready", axi.rready, 1);
        chk("rd_t2_rd_valid", sram_rd_valid, 0);
        axi.rvalid = 1; axi.rdata = 32'hDEAD_BEEF; axi.rresp = 2'b00;
        tick();
        axi.rvalid = 0;
        chk("rd_t3_rd_valid", sram_rd_valid, 1);
        chk("rd_t3_rd_data", sram_rd_data, 32'hDEAD_BEEF);
        chk("rd_t3_rready", axi.rready, 0);
        chk("rd_t3_bus_err", bus_err, 0);
        tick();
        chk("rd_t4_rd_valid", sram_rd_valid, 0);
        chk("rd_t4_rd_data_hold", sram_rd_data, 32'hDEAD_BEEF);

        // Masked write, awready two cycles ahead of wready
        axi.arready = 0;
        sram_wr_en = 1; sram_wr_addr = 32'h2000_0040; sram_wr_data = 32'h1234_5678; sram_wr_mask = 4'b0011;
        tick();
        sram_wr_en = 0;
        chk("wr_c1_busy", sram_wr_busy, 1);
        chk("wr_c1_awvalid", axi.awvalid, 1);
        chk("wr_c1_wvalid", axi.wvalid, 1);
        chk("wr_c1_awaddr", axi.awaddr, 32'h2000_0040);
        chk("wr_c1_wdata", axi.wdata, 32'h1234_5678);
        chk("wr_c1_wstrb", axi.wstrb, 4'b0011);
        axi.awready = 1;
        tick();
        axi.awready = 0;
        chk("wr_c2_awvalid", axi.awvalid, 0);
        chk("wr_c2_wvalid", axi.wvalid, 1);
        sram_wr_en = 1; sram_wr_data = 32'hFFFF_0000; sram_wr_mask = 4'b1111;
        tick();
        sram_wr_en = 0;
        chk("wr_c3_wvalid", axi.wvalid, 1);
        chk("wr_c3_wdata_kept", axi.wdata, 32'h1234_5678);
        chk("wr_c3_wstrb_kept", axi.wstrb, 4'b0011);
        axi.wready = 1;
        tick();
        axi.wready = 0;
        chk("wr_c4_wvalid", axi.wvalid, 0);
        chk("wr_c4_bready", axi.bready, 1);
        chk("wr_c4_busy", sram_wr_busy, 1);
        axi.bvalid = 1; axi.bresp = 2'b00;
        tick();
        axi.bvalid = 0;
        chk("wr_c5_busy", sram_wr_busy, 0);
        chk("wr_c5_bready", axi.bready, 0);
        chk("wr_aw_count", aw_cnt, 1);
        chk("wr_w_count", w_cnt, 1);
        chk("wr_b_count", b_cnt, 1);
        chk("wr_bus_err", bus_err, 0);

        // Simultaneous write and read to the same address
        sram_wr_en = 1; sram_wr_addr = 32'h3000_0000; sram_wr_data = 32'hCAFE_F00D; sram_wr_mask = 4'b1111;
        sram_rd_en = 1; sram_rd_addr = 32'h3000_0000;
        tick();
        sram_wr_en = 0; sram_rd_en = 0;
        chk("raw_d1_awvalid", axi.awvalid, 1);
        chk("raw_d1_arvalid", axi.arvalid, 0);
        axi.awready = 1; axi.wready = 1;
        tick();
        axi.awready = 0; axi.wready = 0;
        chk("raw_d2_bready", axi.bready, 1);
        chk("raw_d2_arvalid", axi.arvalid, 0);
        axi.bvalid = 1;
        tick();
        axi.bvalid = 0;
        chk("raw_d3_arvalid", axi.arvalid, 1);
        chk("raw_d3_araddr", axi.araddr, 32'h3000_0000);
        chk("raw_d3_busy", sram_wr_busy, 0);
        axi.arready = 1;
        tick();
        axi.arready = 0;
        chk("raw_d4_rready", axi.rready, 1);
        axi.rvalid = 1; axi.rdata = 32'hCAFE_F00D;
        tick();
        axi.rvalid = 0;
        chk("raw_d5_rd_valid", sram_rd_valid, 1);
        chk("raw_d5_rd_data", sram_rd_data, 32'hCAFE_F00D);
        tick();

        // Cancel one cycle after arvalid, arready stalled three cycles
        sram_rd_en = 1; sram_rd_addr = 32'h4000_0000;
        tick();
        sram_rd_en = 0;
        chk("cx_e1_arvalid", axi.arvalid, 1);
        tick();
        sram_cancel_rd = 1;
        chk("cx_e2_arvalid", axi.arvalid, 1);
        tick();
        sram_cancel_rd = 0;
        sram_rd_en = 1; sram_rd_addr = 32'h6000_0000;
        chk("cx_e3_arvalid", axi.arvalid, 1);
        chk("cx_e3_araddr", axi.araddr, 32'h4000_0000);
        tick();
        sram_rd_en = 0;
        chk("cx_e4_araddr", axi.araddr, 32'h4000_0000);
        axi.arready = 1;
        tick();
        axi.arready = 0;
        chk("cx_e5_arvalid", axi.arvalid, 0);
        chk("cx_e5_rready", axi.rready, 1);
        chk("cx_ar_count", ar_cnt, 3);
        axi.rvalid = 1; axi.rdata = 32'h5555_5555;
        tick();
        axi.rvalid = 0;
        chk("cx_e6_rd_valid", sram_rd_valid, 0);
        chk("cx_e6_rd_data", sram_rd_data, 32'hCAFE_F00D);
        chk("cx_e6_rready", axi.rready, 0);
        chk("cx_e6_arvalid", axi.arvalid, 0);
        tick();
        chk("cx_e7_rd_valid", sram_rd_valid, 0);
        chk("cx_e7_arvalid", axi.arvalid, 0);

        // SLVERR on a read
        sram_rd_en = 1; sram_rd_addr = 32'h7000_0004; axi.arready = 1;
        tick();
        sram_rd_en = 0;
        chk("er_f1_arvalid", axi.arvalid, 1);
        tick();
        axi.arready = 0;
        axi.rvalid = 1; axi.rdata = 32'h0BAD_F00D; axi.rresp = 2'b10;
        tick();
        axi.rvalid = 0; axi.rresp = 2'b00;
        chk("er_f3_bus_err", bus_err, 1);
        chk("er_f3_rd_valid", sram_rd_valid, 1);
        chk("er_f3_rd_data", sram_rd_data, 32'h0BAD_F00D);
        tick();
        chk("er_f4_bus_err", bus_err, 0);

        // Read cancelled while waiting behind a write that gets an error B
        sram_wr_en = 1; sram_wr_addr = 32'h5000_0000; sram_wr_data = 32'h0000_00A5; sram_wr_mask = 4'b0001;
        sram_rd_en = 1; sram_rd_addr = 32'h5000_0000;
        axi.awready = 1; axi.wready = 1;
        tick();
        sram_wr_en = 0; sram_rd_en = 0;
        sram_cancel_rd = 1;
        chk("cw_g1_arvalid", axi.arvalid, 0);
        tick();
        sram_cancel_rd = 0;
        axi.awready = 0; axi.wready = 0;
        chk("cw_g2_bready", axi.bready, 1);
        axi.bvalid = 1; axi.bresp = 2'b11;
        tick();
        axi.bvalid = 0; axi.bresp = 2'b00;
        chk("cw_g3_bus_err", bus_err, 1);
        chk("cw_g3_arvalid", axi.arvalid, 0);
        tick();
        chk("cw_g4_arvalid", axi.arvalid, 0);
        chk("cw_g4_bus_err", bus_err, 0);
        chk("cw_ar_count", ar_cnt, 4);

        // Reset while waiting for B
        sram_wr_en = 1; sram_wr_addr = 32'h6000_0010; sram_wr_data = 32'h1111_2222; sram_wr_mask = 4'b1111;
        axi.awready = 1; axi.wready = 1;
        tick();
        sram_wr_en = 0;
        tick();
        axi.awready = 0; axi.wready = 0;
        chk("rs_h2_bready", axi.bready, 1);
        chk("rs_h2_busy", sram_wr_busy, 1);
        reset = 1;
        tick();
        chk("rs_h3_bready", axi.bready, 0);
        chk("rs_h3_busy", sram_wr_busy, 0);
        chk("rs_h3_rd_data", sram_rd_data, 0);
        reset = 0;
        tick();
        chk("rs_h4_awvalid", axi.awvalid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dram_axi_bridge.md
DRAM_AXI_BRIDGE -- requirements
Module: dram_axi_bridge

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, meaning the address width on both sides.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning the data width on both sides (single-beat transfers only).
REQ-003 SHALL have port clock, input, 1, the single clock; all logic is rising-edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port sram_rd_en, input, 1, read request pulse from the core data port.
REQ-006 SHALL have port sram_rd_addr, input, ADDR_WIDTH, read address, sampled with sram_rd_en.
REQ-007 SHALL have port sram_cancel_rd, input, 1, abandons the outstanding read.
REQ-008 SHALL have port sram_rd_data, output, DATA_WIDTH, returned read data.
REQ-009 SHALL have port sram_rd_valid, output, 1, one-cycle pulse marking sram_rd_data valid.
REQ-010 SHALL have ports sram_wr_en (input, 1), sram_wr_addr (input, ADDR_WIDTH), sram_wr_data (input, DATA_WIDTH) and sram_wr_mask (input, 4), forming the write request and byte enables.
REQ-011 SHALL have port sram_wr_busy, output, 1, high while a write is in flight.
REQ-012 SHALL have AXI4 master read ports arvalid/arready/araddr[ADDR_WIDTH]/arlen[8]/arsize[3]/arburst[2] and rvalid/rready/rdata[DATA_WIDTH]/rresp[2]/rlast.
REQ-013 SHALL have AXI4 master write ports awvalid/awready/awaddr/awlen/awsize/awburst, wvalid/wready/wdata/wstrb[4]/wlast and bvalid/bready/bresp[2].
REQ-014 SHALL have port bus_err, output, 1, one-cycle pulse on any non-OKAY rresp or bresp.

Function
REQ-015 SHALL drive arlen=awlen=0, arsize=awsize=3'b010, arburst=awburst=2'b01 and wlast=1 constantly; all IDs are fixed at 0.
REQ-016 Read FSM SHALL have states R_IDLE, R_WAIT, R_ADDR, R_DATA, R_DROP.
REQ-017 R_IDLE + sram_rd_en SHALL latch the address and go to R_ADDR if the write FSM is idle and sram_wr_en is low, otherwise to R_WAIT.
REQ-018 R_WAIT SHALL go to R_ADDR in the cycle after the write FSM returns to idle.
REQ-019 R_ADDR SHALL hold arvalid=1 with a stable araddr until arready, then go to R_DATA.
REQ-020 R_DATA SHALL hold rready=1; on rvalid it SHALL register rdata into sram_rd_data, pulse sram_rd_valid the next cycle and return to R_IDLE.
REQ-021 Minimum read latency SHALL be rd_en at cycle t, arvalid at t+1, and rd_valid one cycle after the R handshake.
REQ-022 sram_rd_data SHALL hold its value until the next completed read.
REQ-023 sram_cancel_rd SHALL act as follows: in R_WAIT, go to R_IDLE with no AXI traffic; in R_ADDR, keep arvalid up until arready, then go to R_DROP; in R_DATA, go to R_DROP; in R_IDLE, be ignored.
REQ-024 R_DROP SHALL accept and discard the R beat (rready=1) without asserting sram_rd_valid, then go to R_IDLE.
REQ-025 sram_rd_en while the read FSM is not in R_IDLE SHALL be ignored.
REQ-026 Write FSM SHALL have states W_IDLE, W_SEND, W_RESP.
REQ-027 W_IDLE + sram_wr_en SHALL latch addr/data/mask and go to W_SEND.
REQ-028 W_SEND SHALL raise awvalid and wvalid together and track aw_done and w_done independently; each valid drops after its own handshake.
REQ-029 W_SEND SHALL go to W_RESP once both handshakes have occurred; both in the same cycle is legal.
REQ-030 W_RESP SHALL hold bready=1 and go to W_IDLE on bvalid.
REQ-031 sram_wr_busy SHALL be high in W_SEND and W_RESP and low in W_IDLE; sram_wr_en while busy SHALL be ignored.
REQ-032 When sram_rd_en and sram_wr_en assert in the same cycle, the write SHALL complete (B received) before arvalid rises (read-after-write ordering).
REQ-033 No AR SHALL be issued while the write FSM is in W_SEND or W_RESP.
REQ-034 A new write MAY be accepted while a read is in R_ADDR, R_DATA or R_DROP.
REQ-035 Error responses SHALL still complete the transaction normally and pulse bus_err for one cycle, including on dropped reads.

Reset
REQ-036 reset SHALL force R_IDLE and W_IDLE, clear aw_done and w_done, and drive all valid/ready outputs, sram_rd_valid, sram_wr_busy and bus_err to 0, and sram_rd_data to 0.
REQ-037 Reset mid-transaction SHALL abandon all state without waiting for AXI completion; the environment resets the slave concurrently.

Verification
REQ-038 Read to 0x1C000000 with arready=1 and rdata=0xDEADBEEF at t+2 SHALL give arvalid at t+1, sram_rd_valid pulsed at t+3 with data 0xDEADBEEF, and rready high during R_DATA.
REQ-039 Write 0x12345678 with mask 4'b0011 where awready comes 2 cycles before wready SHALL give wstrb=0011, sram_wr_busy high until the bvalid cycle, and exactly one AW, one W and one B.
REQ-040 Simultaneous write to A and read from A SHALL keep arvalid low until the cycle after the B handshake, then issue the read; the returned data is the slave's post-write value.
REQ-041 sram_cancel_rd asserted one cycle after arvalid with arready stalled 3 cycles SHALL complete AR and R with sram_rd_valid never asserted and sram_rd_data unchanged.
REQ-042 rresp=2'b10 on a read SHALL pulse bus_err and sram_rd_valid in the same cycle; reset asserted during W_RESP SHALL drop bready and sram_wr_busy to 0 on the next edge.
